// File: rtl/dual_issue_dispatch_if.sv
// Fetch-side and issue-side signal bundle for the dual-issue dispatch stage.
// master drives fetch words and stall/flush; slave is the dispatch queue.
interface dual_issue_dispatch_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned OW = $clog2(DEPTH) + 1;

  logic [1:0]    in_valid;
  logic [31:0]   in_instr0;
  logic [31:0]   in_instr1;
  logic [31:0]   in_pc;
  logic [1:0]    in_even;
  logic          in_ready;
  logic          stall;
  logic          flush;
  logic [31:0]   instructionEven;
  logic [31:0]   instructionOdd;
  logic [31:0]   PCout;
  logic [1:0]    issue_valid;
  logic [OW-1:0] occupancy;

  modport master (
    output in_valid,
    output in_instr0,
    output in_instr1,
    output in_pc,
    output in_even,
    output stall,
    output flush,
    input  in_ready,
    input  instructionEven,
    input  instructionOdd,
    input  PCout,
    input  issue_valid,
    input  occupancy
  );

  modport slave (
    input  in_valid,
    input  in_instr0,
    input  in_instr1,
    input  in_pc,
    input  in_even,
    input  stall,
    input  flush,
    output in_ready,
    output instructionEven,
    output instructionOdd,
    output PCout,
    output issue_valid,
    output occupancy
  );
endinterface

// File: rtl/dual_issue_dispatch.sv
// In-order instruction queue with even/odd pipe steering.
// Issues up to one even and one odd instruction per cycle, NOP-filled.
module dual_issue_dispatch #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] NOP_EVEN = 32'h40200000,
  parameter logic [31:0] NOP_ODD  = 32'h00200000
) (
  input logic clk,
  input logic reset,
  dual_issue_dispatch_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      pc_q    [DEPTH];
  logic [DEPTH-1:0] even_q;

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_nxt;
  logic [AW-1:0] wr_nxt;
  logic [AW:0]   count;
  logic [AW:0]   free;
  logic [AW:0]   push_n;
  logic [AW:0]   pop_n;
  logic          h_even;
  logic          pair;

  logic [31:0] ins_even;
  logic [31:0] ins_odd;
  logic [31:0] pc_r;
  logic [1:0]  iv_r;

  assign rd_nxt = rd_ptr + AW'(1);
  assign wr_nxt = wr_ptr + AW'(1);
  assign free   = (AW+1)'(DEPTH) - count;
  assign h_even = even_q[rd_ptr];
  // second entry is only visible when it is already in the queue
  assign pair   = (count >= (AW+1)'(2)) &&
                  (even_q[rd_nxt] != h_even);

  assign bus.in_ready        = free >= (AW+1)'(2);
  assign bus.instructionEven = ins_even;
  assign bus.instructionOdd  = ins_odd;
  assign bus.PCout           = pc_r;
  assign bus.issue_valid     = iv_r;
  assign bus.occupancy       = count;

  // number of words accepted this cycle, slot0 first
  always_comb begin
    push_n = '0;
    if (bus.in_ready && !bus.flush) begin
      if (bus.in_valid[0]) begin
        push_n = bus.in_valid[1] ? (AW+1)'(2)
                                 : (AW+1)'(1);
      end
    end
  end

  // number of entries retired by the issue stage this cycle
  always_comb begin
    pop_n = '0;
    if (!bus.stall && !bus.flush && count != '0) begin
      pop_n = pair ? (AW+1)'(2) : (AW+1)'(1);
    end
  end

  // queue storage; contents are don't-care outside the live window
  always_ff @(posedge clk) begin
    if (push_n != '0) begin
      instr_q[wr_ptr] <= bus.in_instr0;
      pc_q[wr_ptr]    <= bus.in_pc;
      even_q[wr_ptr]  <= bus.in_even[0];
    end
    if (push_n == (AW+1)'(2)) begin
      instr_q[wr_nxt] <= bus.in_instr1;
      pc_q[wr_nxt]    <= bus.in_pc + 32'd4;
      even_q[wr_nxt]  <= bus.in_even[1];
    end
  end

  // pointer and occupancy bookkeeping; flush empties the queue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + pop_n[AW-1:0];
      wr_ptr <= wr_ptr + push_n[AW-1:0];
      count  <= count + push_n - pop_n;
    end
  end

  // issue registers: steer head (and partner) to their pipes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ins_even <= NOP_EVEN;
      ins_odd  <= NOP_ODD;
      pc_r     <= '0;
      iv_r     <= '0;
    end else if (bus.flush) begin
      ins_even <= NOP_EVEN;
      ins_odd  <= NOP_ODD;
      iv_r     <= '0;
    end else if (!bus.stall) begin
      unique case (1'b1)
        count == '0: begin
          ins_even <= NOP_EVEN;
          ins_odd  <= NOP_ODD;
          iv_r     <= '0;
        end
        pair: begin
          if (h_even) begin
            ins_even <= instr_q[rd_ptr];
            ins_odd  <= instr_q[rd_nxt];
          end else begin
            ins_even <= instr_q[rd_nxt];
            ins_odd  <= instr_q[rd_ptr];
          end
          pc_r <= pc_q[rd_ptr];
          iv_r <= 2'b11;
        end
        default: begin
          if (h_even) begin
            ins_even <= instr_q[rd_ptr];
            ins_odd  <= NOP_ODD;
            iv_r     <= 2'b01;
          end else begin
            ins_even <= NOP_EVEN;
            ins_odd  <= instr_q[rd_ptr];
            iv_r     <= 2'b10;
          end
          pc_r <= pc_q[rd_ptr];
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dual_issue_dispatch.sv
// Scoreboard bench for dual_issue_dispatch.
// Reference queue predicts each edge; expectations popped after it.
module tb_dual_issue_dispatch;
  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] NOP_E = 32'h40200000;
  localparam logic [31:0] NOP_O = 32'h00200000;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ev;
  } ent_t;

  typedef struct {
    logic [31:0] even;
    logic [31:0] odd;
    logic [31:0] pc;
    logic [1:0]  iv;
    int          occ;
  } exp_t;

  logic clk;
  logic reset;

  dual_issue_dispatch_if #(.DEPTH(DEPTH)) bus ();

  dual_issue_dispatch #(
    .DEPTH   (DEPTH),
    .NOP_EVEN(NOP_E),
    .NOP_ODD (NOP_O)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  ent_t mq[$];
  exp_t exp_q[$];
  logic [31:0] m_even;
  logic [31:0] m_odd;
  logic [31:0] m_pc;
  logic [1:0]  m_iv;
  logic [31:0] pc_ctr;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_even = NOP_E;
    m_odd  = NOP_O;
    m_pc   = '0;
    m_iv   = '0;
  endtask

  task automatic drive(logic [1:0] v, logic [31:0] i0,
                       logic [31:0] i1, logic [31:0] pc,
                       logic [1:0] ev);
    bus.in_valid  = v;
    bus.in_instr0 = i0;
    bus.in_instr1 = i1;
    bus.in_pc     = pc;
    bus.in_even   = ev;
  endtask

  task automatic idle_in();
    drive(2'b00, '0, '0, '0, 2'b00);
  endtask

  // predict one edge, advance, then compare against the popped record
  task automatic step();
    exp_t e;
    ent_t h;
    bit rdy;
    rdy = (DEPTH - mq.size()) >= 2;
    chk("in_ready", {63'd0, bus.in_ready}, {63'd0, rdy});
    if (bus.flush) begin
      mq.delete();
      m_even = NOP_E;
      m_odd  = NOP_O;
      m_iv   = '0;
    end else begin
      if (!bus.stall) begin
        if (mq.size() == 0) begin
          m_even = NOP_E;
          m_odd  = NOP_O;
          m_iv   = '0;
        end else begin
          h = mq.pop_front();
          m_pc = h.pc;
          if (mq.size() >= 1 && mq[0].ev != h.ev) begin
            if (h.ev) begin
              m_even = h.instr;
              m_odd  = mq[0].instr;
            end else begin
              m_even = mq[0].instr;
              m_odd  = h.instr;
            end
            m_iv = 2'b11;
            void'(mq.pop_front());
          end else if (h.ev) begin
            m_even = h.instr;
            m_odd  = NOP_O;
            m_iv   = 2'b01;
          end else begin
            m_even = NOP_E;
            m_odd  = h.instr;
            m_iv   = 2'b10;
          end
        end
      end
      if (rdy && bus.in_valid[0]) begin
        mq.push_back('{bus.in_instr0, bus.in_pc, bus.in_even[0]});
        if (bus.in_valid[1])
          mq.push_back('{bus.in_instr1, bus.in_pc + 32'd4,
                         bus.in_even[1]});
      end
    end
    e = '{m_even, m_odd, m_pc, m_iv, mq.size()};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("even", {32'd0, bus.instructionEven}, {32'd0, e.even});
    chk("odd",  {32'd0, bus.instructionOdd},  {32'd0, e.odd});
    chk("pc",   {32'd0, bus.PCout},           {32'd0, e.pc});
    chk("iv",   {62'd0, bus.issue_valid},     {62'd0, e.iv});
    chk("occ",  {60'd0, bus.occupancy},       64'(e.occ));
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_even"}, {32'd0, bus.instructionEven}, {32'd0, NOP_E});
    chk({tag, "_odd"},  {32'd0, bus.instructionOdd},  {32'd0, NOP_O});
    chk({tag, "_pc"},   {32'd0, bus.PCout},           64'd0);
    chk({tag, "_iv"},   {62'd0, bus.issue_valid},     64'd0);
    chk({tag, "_occ"},  {60'd0, bus.occupancy},       64'd0);
    chk({tag, "_rdy"},  {63'd0, bus.in_ready},        64'd1);
  endtask

  task automatic drain(string tag, int budget);
    int n;
    n = 0;
    while (mq.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (mq.size() != 0)
      chk({tag, "_timeout"}, 64'(mq.size()), 64'd0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    pc_ctr = 32'h100;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    idle_in();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: reset values then idle
    chk_reset_vals("rst");
    step();
    step();

    // 2: even+odd pair issues together
    drive(2'b11, 32'h18000001, 32'h3bc00002, 32'h0, 2'b01);
    step();
    idle_in();
    step();
    step();

    // 3: two even words issue one per cycle
    drive(2'b11, 32'h78800003, 32'h79800004, 32'h8, 2'b11);
    step();
    idle_in();
    step();
    step();
    step();

    // 4: odd-then-even pair, then stall 3 cycles
    drive(2'b11, 32'h32000005, 32'h19000006, 32'h10, 2'b10);
    step();
    idle_in();
    step();
    drive(2'b11, 32'h18000007, 32'h18000008, 32'h18, 2'b11);
    step();
    idle_in();
    bus.stall = 1'b1;
    repeat (3) step();
    bus.stall = 1'b0;
    drain("t4", 10);
    step();

    // 5: fill under stall until full, extra words dropped, drain
    bus.stall = 1'b1;
    for (int i = 0; i < 12 && bus.in_ready; i++) begin
      drive(2'b11, 32'hA000_0000 | i, 32'hB000_0000 | i,
            pc_ctr, 2'(i % 3 == 0 ? 2'b10 : (i % 3 == 1 ? 2'b11 : 2'b00)));
      pc_ctr += 8;
      step();
    end
    drive(2'b01, 32'hDEAD0001, '0, pc_ctr, 2'b01);
    step();
    drive(2'b11, 32'hDEAD0002, 32'hDEAD0003, pc_ctr, 2'b01);
    step();
    chk("t5_full", {63'd0, bus.in_ready}, 64'd0);
    idle_in();
    bus.stall = 1'b0;
    drain("t5", 20);
    step();

    // 6: queue holding 5, flush with push and stall together
    bus.stall = 1'b1;
    drive(2'b11, 32'hC0000001, 32'hC0000002, 32'h200, 2'b01);
    step();
    drive(2'b11, 32'hC0000003, 32'hC0000004, 32'h208, 2'b10);
    step();
    drive(2'b01, 32'hC0000005, '0, 32'h210, 2'b00);
    step();
    chk("t6_hold5", {60'd0, bus.occupancy}, 64'd5);
    drive(2'b11, 32'hEEEE0001, 32'hEEEE0002, 32'h300, 2'b01);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    idle_in();
    chk("t6_flush_occ", {60'd0, bus.occupancy}, 64'd0);
    step();
    step();

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      logic [1:0] v;
      v = ($urandom_range(0, 2) == 0) ? 2'b00
        : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11);
      drive(v, $urandom, $urandom, pc_ctr, 2'($urandom_range(0, 3)));
      pc_ctr += 8;
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 24) == 0);
      step();
    end
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    idle_in();
    drain("rnd", 20);

    // async reset mid-drain
    drive(2'b11, 32'h11110001, 32'h11110002, 32'h400, 2'b11);
    step();
    drive(2'b11, 32'h11110003, 32'h11110004, 32'h408, 2'b01);
    step();
    idle_in();
    step();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk_reset_vals("async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
